layer_sequencer: RTL and testbench

// - Table-driven successor to the fixed CNN top-level schedule: walks a programmable list of layer descriptors (CONV/MAXP/DENSE/RESULT).
// - Per layer, issues one start pulse per pass to the selected engine (conv_TOP, maxp, dense, result) and drives its pixel, weight and write base addresses.
// - Ping-pongs between two pixel buffers, accumulates the weight base, and latches the class result.
// - Replaces hard-coded TOPlvl/step decoding; supports any depth up to MAX_LAYERS and any channel count up to 2**CH_W.

---
 rtl/layer_seq_pkg.sv | 46 ++++
 rtl/layer_addr_gen.sv | 80 ++++++++
 rtl/layer_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and descriptor layout for the layer sequencer.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        OP_CONV   = 2'd0,
        OP_MAXP   = 2'd1,
        OP_DENSE  = 2'd2,
        OP_RESULT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    // Descriptor layout, LSB first: op, in_ch-1, out_ch-1, matrix, globmaxp, last
    localparam int OP_LSB    = 0;
    localparam int OP_W      = 2;
    localparam int IN_CH_LSB = OP_LSB + OP_W;

    function automatic int out_ch_lsb(input int ch_w);
        return IN_CH_LSB + ch_w;
    endfunction

    function automatic int matrix_lsb(input int ch_w);
        return IN_CH_LSB + 2 * ch_w;
    endfunction

    function automatic int globmaxp_bit(input int ch_w, input int mat_w);
        return matrix_lsb(ch_w) + mat_w;
    endfunction

    function automatic int last_bit(input int ch_w, input int mat_w);
        return globmaxp_bit(ch_w, mat_w) + 1;
    endfunction

    function automatic int desc_w(input int ch_w, input int mat_w);
        return last_bit(ch_w, mat_w) + 1;
    endfunction

endpackage

// File: rtl/layer_addr_gen.sv
// Per-pass base-address calculator: combinational arithmetic captured on load.
module layer_addr_gen
    import layer_seq_pkg::*;
#(
    parameter int CH_W     = 5,
    parameter int MAT_W    = 5,
    parameter int ADDR_PIX = 13,
    parameter int ADDR_WEI = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  op_e                 op,
    input  logic [CH_W-1:0]     ic,
    input  logic [CH_W-1:0]     oc,
    input  logic [CH_W-1:0]     in_ch_m1,
    input  logic [MAT_W-1:0]    matrix,
    input  logic                globmaxp,
    input  logic [ADDR_PIX-1:0] src,
    input  logic [ADDR_PIX-1:0] dst,
    input  logic [ADDR_WEI-1:0] wbase,
    output logic [ADDR_PIX-1:0] memstartp,
    output logic [ADDR_WEI-1:0] memstartw,
    output logic [ADDR_PIX-1:0] memstartzap,
    output logic                bias,
    output logic                globmaxp_en
);

    logic [ADDR_PIX-1:0] m2;
    logic [ADDR_PIX-1:0] ic_p;
    logic [ADDR_PIX-1:0] oc_p;
    logic [ADDR_WEI-1:0] in_ch_w;
    logic [ADDR_PIX-1:0] p_c;
    logic [ADDR_PIX-1:0] zap_c;
    logic [ADDR_WEI-1:0] w_c;
    logic                bias_c;

    // Address arithmetic for the current pass; products wrap at the port width
    always_comb begin
        m2      = ADDR_PIX'(matrix) * ADDR_PIX'(matrix);
        ic_p    = ADDR_PIX'(ic);
        oc_p    = ADDR_PIX'(oc);
        in_ch_w = ADDR_WEI'(in_ch_m1) + ADDR_WEI'(1);
        p_c     = src;
        w_c     = wbase;
        zap_c   = dst;
        bias_c  = 1'b0;
        case (op)
            OP_CONV: begin
                p_c    = src + ic_p * m2;
                w_c    = wbase + ADDR_WEI'(oc) * in_ch_w + ADDR_WEI'(ic);
                zap_c  = dst + oc_p * m2;
                bias_c = (ic == in_ch_m1);
            end
            OP_MAXP: begin
                p_c   = src + ic_p * m2;
                zap_c = dst + ic_p * (m2 >> 2);
            end
            default: ;
        endcase
    end

    // Capture the pass addresses so they stay stable while the engine runs
    always_ff @(posedge clk) begin
        if (rst) begin
            memstartp   <= '0;
            memstartw   <= '0;
            memstartzap <= '0;
            bias        <= 1'b0;
            globmaxp_en <= 1'b0;
        end else if (load) begin
            memstartp   <= p_c;
            memstartw   <= w_c;
            memstartzap <= zap_c;
            bias        <= bias_c;
            globmaxp_en <= globmaxp & bias_c;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks a programmable layer-descriptor table, issuing one engine start per pass.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int MAX_LAYERS = 16,
    parameter int CH_W       = 5,
    parameter int MAT_W      = 5,
    parameter int ADDR_PIX   = 13,
    parameter int ADDR_WEI   = 9,
    parameter int BUF_A      = 0,
    parameter int BUF_B      = 3136,
    localparam int IDX_W     = $clog2(MAX_LAYERS),
    localparam int DESC_W    = desc_w(CH_W, MAT_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [DESC_W-1:0]   cfg_data,
    input  logic                GO,
    input  logic                eng_done,
    input  logic                res_valid,
    input  logic [3:0]          res_class,
    output logic                eng_start,
    output logic [3:0]          eng_sel,
    output logic [ADDR_PIX-1:0] memstartp,
    output logic [ADDR_WEI-1:0] memstartw,
    output logic [ADDR_PIX-1:0] memstartzap,
    output logic [MAT_W-1:0]    matrix,
    output logic                bias,
    output logic                globmaxp_en,
    output logic                busy,
    output logic                STOP,
    output logic                err,
    output logic [3:0]          RESULT
);

    localparam int OUT_LSB = out_ch_lsb(CH_W);
    localparam int MAT_LSB = matrix_lsb(CH_W);
    localparam int GMP_BIT = globmaxp_bit(CH_W, MAT_W);
    localparam int LST_BIT = last_bit(CH_W, MAT_W);

    state_e              state, state_nxt;
    logic [DESC_W-1:0]   desc_mem [MAX_LAYERS];
    logic [DESC_W-1:0]   desc_q;
    logic [IDX_W-1:0]    idx;
    logic [CH_W-1:0]     ic, oc;
    logic [ADDR_PIX-1:0] src, dst;
    logic [ADDR_WEI-1:0] wbase;
    logic                stop_q, err_q, eng_start_q;
    logic [3:0]          class_q;

    op_e                 d_op;
    logic [CH_W-1:0]     d_in, d_out;
    logic                d_gmp, d_last;
    logic                idle_like, pass_done, more_passes, idx_at_end;

    assign d_op   = op_e'(desc_q[OP_LSB +: OP_W]);
    assign d_in   = desc_q[IN_CH_LSB +: CH_W];
    assign d_out  = desc_q[OUT_LSB +: CH_W];
    assign matrix = desc_q[MAT_LSB +: MAT_W];
    assign d_gmp  = desc_q[GMP_BIT];
    assign d_last = desc_q[LST_BIT];

    assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign busy       = !idle_like;
    assign idx_at_end = (idx == IDX_W'(MAX_LAYERS - 1));
    assign pass_done  = (state == ST_WAIT) &&
                        (eng_done || ((d_op == OP_RESULT) && res_valid));

    assign eng_start  = eng_start_q;
    assign STOP       = stop_q;
    assign err        = err_q;
    assign RESULT     = stop_q ? class_q : 4'b1111;

    // Decide whether the current layer still has passes left to issue
    always_comb begin
        more_passes = 1'b0;
        case (d_op)
            OP_CONV: more_passes = !((ic == d_in) && (oc == d_out));
            OP_MAXP: more_passes = (ic != d_in);
            default: more_passes = 1'b0;
        endcase
    end

    // Engine select is held across ISSUE and WAIT of each pass
    always_comb begin
        eng_sel = '0;
        if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
            eng_sel = 4'b0001 << d_op;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decoding
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (GO) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (pass_done) state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (more_passes)     state_nxt = ST_ISSUE;
                else if (d_last)     state_nxt = ST_DONE;
                else if (idx_at_end) state_nxt = ST_ERR;
                else                 state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Descriptor table writes are only accepted while the sequencer is idle
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            desc_mem[cfg_addr] <= cfg_data;
        end
    end

    // Layer/pass counters, buffer ping-pong, weight base and run status
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            ic          <= '0;
            oc          <= '0;
            src         <= ADDR_PIX'(BUF_A);
            dst         <= ADDR_PIX'(BUF_B);
            wbase       <= '0;
            desc_q      <= '0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            class_q     <= '0;
            eng_start_q <= 1'b0;
        end else begin
            // start is launched from ISSUE so it coincides with the captured addresses
            eng_start_q <= (state == ST_ISSUE);
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (GO) begin
                        idx     <= '0;
                        ic      <= '0;
                        oc      <= '0;
                        wbase   <= '0;
                        src     <= ADDR_PIX'(BUF_A);
                        dst     <= ADDR_PIX'(BUF_B);
                        stop_q  <= 1'b0;
                        err_q   <= 1'b0;
                        class_q <= '0;
                    end
                end
                ST_FETCH: desc_q <= desc_mem[idx];
                ST_WAIT: begin
                    if ((d_op == OP_RESULT) && res_valid) class_q <= res_class;
                end
                ST_NEXT: begin
                    if (more_passes) begin
                        if ((d_op == OP_CONV) && (ic == d_in)) begin
                            ic <= '0;
                            oc <= oc + CH_W'(1);
                        end else begin
                            ic <= ic + CH_W'(1);
                        end
                    end else begin
                        ic  <= '0;
                        oc  <= '0;
                        idx <= idx + IDX_W'(1);
                        if (d_op != OP_RESULT) begin
                            src <= dst;
                            dst <= src;
                        end
                        if ((d_op == OP_CONV) || (d_op == OP_DENSE)) begin
                            wbase <= wbase + (ADDR_WEI'(d_in) + ADDR_WEI'(1)) *
                                             (ADDR_WEI'(d_out) + ADDR_WEI'(1));
                        end
                        if (d_last)          stop_q <= 1'b1;
                        else if (idx_at_end) err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    layer_addr_gen #(
        .CH_W     (CH_W),
        .MAT_W    (MAT_W),
        .ADDR_PIX (ADDR_PIX),
        .ADDR_WEI (ADDR_WEI)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (state == ST_ISSUE),
        .op          (d_op),
        .ic          (ic),
        .oc          (oc),
        .in_ch_m1    (d_in),
        .matrix      (matrix),
        .globmaxp    (d_gmp),
        .src         (src),
        .dst         (dst),
        .wbase       (wbase),
        .memstartp   (memstartp),
        .memstartw   (memstartw),
        .memstartzap (memstartzap),
        .bias        (bias),
        .globmaxp_en (globmaxp_en)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: descriptor-level reference model plus directed corners.
module tb_layer_sequencer;
    import layer_seq_pkg::*;

    localparam int DW = desc_w(5, 5);

    logic        clk = 1'b0;
    logic        rst, cfg_we, GO, eng_done, res_valid;
    logic [3:0]  cfg_addr, res_class;
    logic [DW-1:0] cfg_data;
    logic        eng_start, bias, globmaxp_en, busy, STOP, err;
    logic [3:0]  eng_sel, RESULT;
    logic [12:0] memstartp, memstartzap;
    logic [8:0]  memstartw;
    logic [4:0]  matrix;

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .GO(GO), .eng_done(eng_done), .res_valid(res_valid), .res_class(res_class),
        .eng_start(eng_start), .eng_sel(eng_sel), .memstartp(memstartp), .memstartw(memstartw),
        .memstartzap(memstartzap), .matrix(matrix), .bias(bias), .globmaxp_en(globmaxp_en),
        .busy(busy), .STOP(STOP), .err(err), .RESULT(RESULT)
    );

    typedef struct {
        int sel; int p; int w; int zap; int mat;
        bit chk_w; bit chk_zap; bit bias; bit gmp;
    } start_t;

    typedef struct {
        int op; int n_in; int n_out; int mat; bit gmp; int exp_starts; int exp_result;
    } vec_t;

    start_t exp_q[$];
    start_t obs_q[$];
    int t_op[16], t_in[16], t_out[16], t_mat[16];
    bit t_gmp[16], t_last[16];
    bit exp_stop, exp_err;
    int exp_cls;
    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    // Expected start list derived from the descriptor rules with plain integer arithmetic
    function automatic void build_model();
        int src, dst, wb, tmp, m2, n_in, n_out;
        bit ended;
        start_t s;
        exp_q.delete();
        src = 0; dst = 3136; wb = 0; ended = 0;
        exp_stop = 0; exp_err = 0; exp_cls = 0;
        for (int l = 0; l < 16 && !ended; l++) begin
            m2 = t_mat[l] * t_mat[l];
            n_in = t_in[l]; n_out = t_out[l];
            s.mat = t_mat[l]; s.w = 0; s.zap = 0;
            s.chk_w = 0; s.chk_zap = 1; s.bias = 0; s.gmp = 0;
            case (t_op[l])
                0: for (int oc = 0; oc < n_out; oc++) begin
                       for (int ic = 0; ic < n_in; ic++) begin
                           s.sel = 1;
                           s.p = (src + ic * m2) % 8192;
                           s.w = (wb + oc * n_in + ic) % 512; s.chk_w = 1;
                           s.zap = (dst + oc * m2) % 8192;
                           s.bias = (ic == n_in - 1);
                           s.gmp = t_gmp[l] && s.bias;
                           exp_q.push_back(s);
                       end
                   end
                1: for (int c = 0; c < n_in; c++) begin
                       s.sel = 2;
                       s.p = (src + c * m2) % 8192;
                       s.zap = (dst + c * (m2 / 4)) % 8192;
                       exp_q.push_back(s);
                   end
                2: begin
                       s.sel = 4; s.p = src; s.w = wb; s.chk_w = 1; s.zap = dst;
                       exp_q.push_back(s);
                   end
                default: begin
                       s.sel = 8; s.p = src; s.chk_zap = 0;
                       exp_q.push_back(s);
                       exp_cls = 7;
                   end
            endcase
            if (t_op[l] != 3) begin tmp = src; src = dst; dst = tmp; end
            if (t_op[l] == 0 || t_op[l] == 2) wb = (wb + n_in * n_out) % 512;
            if (t_last[l]) begin exp_stop = 1; ended = 1; end
            else if (l == 15) exp_err = 1;
        end
    endfunction

    function automatic logic [DW-1:0] enc(input int i);
        logic [4:0] a, b, m;
        logic [1:0] o;
        o = 2'(t_op[i]); a = 5'(t_in[i] - 1); b = 5'(t_out[i] - 1); m = 5'(t_mat[i]);
        return {t_last[i], t_gmp[i], m, b, a, o};
    endfunction

    function automatic void clear_table();
        for (int i = 0; i < 16; i++) begin
            t_op[i] = 0; t_in[i] = 1; t_out[i] = 1; t_mat[i] = 1; t_gmp[i] = 0; t_last[i] = 0;
        end
    endfunction

    function automatic void set_layer(input int i, input int op, input int n_in, input int n_out,
                                      input int mat, input bit gmp, input bit last);
        t_op[i] = op; t_in[i] = n_in; t_out[i] = n_out; t_mat[i] = mat; t_gmp[i] = gmp; t_last[i] = last;
    endfunction

    function automatic void mnist_table();
        clear_table();
        set_layer(0, 0, 1, 4, 28, 0, 0);
        set_layer(1, 0, 4, 4, 28, 0, 0);
        set_layer(2, 1, 4, 1, 28, 0, 0);
        set_layer(3, 0, 4, 8, 14, 0, 0);
        set_layer(4, 0, 8, 8, 14, 0, 0);
        set_layer(5, 1, 8, 1, 14, 0, 0);
        set_layer(6, 0, 8, 16, 7, 0, 0);
        set_layer(7, 0, 16, 16, 7, 1, 0);
        set_layer(8, 2, 16, 11, 1, 0, 0);
        set_layer(9, 3, 1, 1, 1, 0, 1);
    endfunction

    task automatic load_table();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = enc(i);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Runs one GO with a responder that completes each pass 3 cycles after its start
    task automatic run_check(input int max_cyc, input int poke_at, input int rst_at, output int nstart);
        int cnt;
        bit finished, aborted;
        start_t e;
        start_t o;
        build_model();
        obs_q.delete();
        nstart = 0; cnt = 0; finished = 0; aborted = 0;
        @(negedge clk);
        GO = 1'b1;
        for (int cyc = 0; cyc < max_cyc && !finished; cyc++) begin
            @(negedge clk);
            GO = 1'b0; cfg_we = 1'b0; eng_done = 1'b0; res_valid = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check("rst_eng_sel", eng_sel, 0);
                check("rst_busy", busy, 0);
                check("rst_eng_start", eng_start, 0);
                check("rst_stop", STOP, 0);
                aborted = 1; finished = 1;
            end else begin
                if (eng_start) begin
                    o.sel = eng_sel; o.p = memstartp; o.w = memstartw; o.zap = memstartzap;
                    o.mat = matrix; o.bias = bias; o.gmp = globmaxp_en; o.chk_w = 1; o.chk_zap = 1;
                    obs_q.push_back(o);
                    if (nstart < exp_q.size()) begin
                        e = exp_q[nstart];
                        check("eng_sel", eng_sel, e.sel);
                        check("memstartp", memstartp, e.p);
                        if (e.chk_w) check("memstartw", memstartw, e.w);
                        if (e.chk_zap) check("memstartzap", memstartzap, e.zap);
                        check("matrix", matrix, e.mat);
                        check("bias", bias, e.bias);
                        check("globmaxp_en", globmaxp_en, e.gmp);
                    end else begin
                        check("extra_start", nstart + 1, exp_q.size());
                    end
                    nstart++;
                    cnt = 3;
                    if (nstart == poke_at) begin
                        GO = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = '0;
                    end
                    if (nstart == rst_at) rst = 1'b1;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (eng_sel[3]) begin res_valid = 1'b1; res_class = 4'd7; end
                        else eng_done = 1'b1;
                    end
                end
                if (!busy && !rst) finished = 1;
            end
        end
        eng_done = 1'b0; res_valid = 1'b0; GO = 1'b0; cfg_we = 1'b0;
        if (!aborted) begin
            if (!finished) check("run_timeout", 0, 1);
            check("start_count", nstart, exp_q.size());
            check("stop", STOP, exp_stop);
            check("err", err, exp_err);
            check("result", RESULT, exp_stop ? exp_cls : 15);
        end
    endtask

    vec_t vecs[6];
    int ref_p[4], ref_w[4], ref_zap[4], ref_bias[4];

    initial begin
        int n, nl;

        vecs[0] = '{0, 2, 2, 4, 0, 4, 0};
        vecs[1] = '{0, 3, 2, 5, 1, 6, 0};
        vecs[2] = '{1, 3, 1, 8, 0, 3, 0};
        vecs[3] = '{2, 16, 11, 1, 0, 1, 0};
        vecs[4] = '{3, 1, 1, 1, 0, 1, 7};
        vecs[5] = '{0, 32, 1, 2, 0, 32, 0};
        ref_p   = '{0, 16, 0, 16};
        ref_w   = '{0, 1, 2, 3};
        ref_zap = '{3136, 3136, 3152, 3152};
        ref_bias = '{0, 1, 0, 1};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; GO = 1'b0;
        eng_done = 1'b0; res_valid = 1'b0; res_class = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {eng_start, eng_sel, memstartp, memstartw, memstartzap, matrix,
                                bias, globmaxp_en, busy, STOP, err}, 0);
        check("reset_result", RESULT, 15);
        rst = 1'b0;

        // Single-layer tables with known pass counts
        for (int i = 0; i < 6; i++) begin
            clear_table();
            set_layer(0, vecs[i].op, vecs[i].n_in, vecs[i].n_out, vecs[i].mat, vecs[i].gmp, 1);
            load_table();
            run_check(2000, -1, -1, n);
            check("vec_starts", n, vecs[i].exp_starts);
            check("vec_result", RESULT, vecs[i].exp_result);
            if (i == 0) begin
                check("conv22_count", obs_q.size(), 4);
                for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
                    check("conv22_p", obs_q[k].p, ref_p[k]);
                    check("conv22_w", obs_q[k].w, ref_w[k]);
                    check("conv22_zap", obs_q[k].zap, ref_zap[k]);
                    check("conv22_bias", obs_q[k].bias, ref_bias[k]);
                end
            end
        end

        // Full MNIST schedule with GO and cfg_we attempted mid-run
        mnist_table();
        load_table();
        run_check(10000, 50, -1, n);
        check("mnist_stop", STOP, 1);
        check("mnist_class", RESULT, 7);
        // Same table again without reloading: the mid-run write must not have landed
        run_check(10000, -1, -1, n);

        // Reset during WAIT of layer 3, then restart from a freshly loaded table
        run_check(10000, -1, 26, n);
        mnist_table();
        load_table();
        run_check(10000, -1, -1, n);

        // No last bit anywhere: walks all 16 entries then flags an overrun
        clear_table();
        for (int l = 0; l < 16; l++) begin
            set_layer(l, $urandom_range(0, 3), $urandom_range(1, 2), $urandom_range(1, 2),
                      $urandom_range(1, 31), 1'($urandom_range(0, 1)), 0);
        end
        load_table();
        run_check(5000, -1, -1, n);
        check("overrun_err", err, 1);
        check("overrun_stop", STOP, 0);
        check("overrun_result", RESULT, 15);

        // Spurious eng_done during ISSUE must not complete the pass
        clear_table();
        set_layer(0, 2, 16, 11, 1, 0, 1);
        load_table();
        @(negedge clk); GO = 1'b1;
        @(negedge clk); GO = 1'b0;
        @(negedge clk);
        check("issue_eng_sel", eng_sel, 4);
        check("issue_no_start", eng_start, 0);
        eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        check("wait_start", eng_start, 1);
        repeat (3) @(negedge clk);
        check("spur_busy", busy, 1);
        check("spur_eng_sel", eng_sel, 4);
        check("spur_stop", STOP, 0);
        eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        @(negedge clk);
        check("spur_done_stop", STOP, 1);
        check("spur_done_busy", busy, 0);

        // Randomised short tables
        for (int r = 0; r < 12; r++) begin
            clear_table();
            nl = $urandom_range(1, 5);
            for (int l = 0; l < nl; l++) begin
                set_layer(l, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                          $urandom_range(1, 31), 1'($urandom_range(0, 1)), l == nl - 1);
            end
            load_table();
            run_check(3000, -1, -1, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
